// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline definitions: controller state encoding and counter widths.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W       = 5;
    localparam int DIV_CNT_W   = 8;
    localparam int STALL_CNT_W = 16;
    localparam int FLUSH_CNT_W = 8;

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    // A load in EX feeding a source of the ID instruction; R0 never carries a dependency.
    function automatic logic is_load_use(input logic             mem_read,
                                         input logic [REG_W-1:0] rd,
                                         input logic [REG_W-1:0] rs,
                                         input logic [REG_W-1:0] rt);
        return mem_read && (rd != '0) && ((rd == rs) || (rd == rt));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard controller (slave).
//
// Timing contract: there is no valid/ready pairing here. The datapath presents
// ex_mem_read/ex_rd/id_rs/id_rt/branch_taken/div_start every cycle; the controller
// answers combinationally in the same cycle with load enables and clears, and the
// datapath applies them at the next rising clock edge. A clear beats its load.
// dbg_state mirrors the controller FSM for checkers.
interface pipe_hazard_ctrl_if;
    import pipe_hazard_ctrl_pkg::*;

    logic                   ex_mem_read;
    logic [REG_W-1:0]       ex_rd;
    logic [REG_W-1:0]       id_rs;
    logic [REG_W-1:0]       id_rt;
    logic                   branch_taken;
    logic                   div_start;

    logic                   pc_load;
    logic                   ifid_load;
    logic                   idex_load;
    logic                   exmem_load;
    logic                   ifid_clear;
    logic                   idex_clear;
    logic                   exmem_clear;
    logic                   busy;
    logic [STALL_CNT_W-1:0] stall_cycles;
    logic [FLUSH_CNT_W-1:0] flush_events;
    state_t                 dbg_state;

    modport master (
        output ex_mem_read, ex_rd, id_rs, id_rt, branch_taken, div_start,
        input  pc_load, ifid_load, idex_load, exmem_load,
        input  ifid_clear, idex_clear, exmem_clear,
        input  busy, stall_cycles, flush_events, dbg_state
    );

    modport slave (
        input  ex_mem_read, ex_rd, id_rs, id_rt, branch_taken, div_start,
        output pc_load, ifid_load, idex_load, exmem_load,
        output ifid_clear, idex_clear, exmem_clear,
        output busy, stall_cycles, flush_events, dbg_state
    );

endinterface

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   inc,
    output logic [STALL_CNT_W-1:0] count
);

    logic [STALL_CNT_W-1:0] r_count;

    // Count qualifying cycles, holding once the maximum is reached.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch flushes and a
// multi-cycle divide stall, with stall/flush statistics counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int DIV_LAT = 8
)
(
    input  logic               clock,
    input  logic               reset_n,
    pipe_hazard_ctrl_if.slave  hz
);

    // Counter value loaded on entry to MC_BUSY so that the stall lasts DIV_LAT-1 cycles.
    localparam logic [DIV_CNT_W-1:0] DIV_RELOAD = DIV_CNT_W'(DIV_LAT - 2);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DIV_CNT_W-1:0]   r_div_cnt;
    logic [DIV_CNT_W-1:0]   w_div_cnt_nxt;
    logic [FLUSH_CNT_W-1:0] r_flush_events;

    logic w_load_use;
    logic w_flush_inc;
    logic w_stall_inc;
    logic w_pc_load;
    logic w_ifid_load;
    logic w_idex_load;
    logic w_exmem_load;
    logic w_ifid_clear;
    logic w_idex_clear;
    logic w_exmem_clear;

    assign w_load_use = is_load_use(hz.ex_mem_read, hz.ex_rd, hz.id_rs, hz.id_rt);

    // State and divide counter registers; reset abandons any divide in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RUN;
            r_div_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_div_cnt <= w_div_cnt_nxt;
        end
    end

    // Next-state and output decode; hazards act in the cycle they are seen.
    always_comb begin
        w_state_nxt   = r_state;
        w_div_cnt_nxt = r_div_cnt;
        w_flush_inc   = 1'b0;
        w_pc_load     = 1'b1;
        w_ifid_load   = 1'b1;
        w_idex_load   = 1'b1;
        w_exmem_load  = 1'b1;
        w_ifid_clear  = 1'b0;
        w_idex_clear  = 1'b0;
        w_exmem_clear = 1'b0;

        if (!reset_n) begin
            // Freeze and scrub the whole pipeline while reset is held.
            w_pc_load     = 1'b0;
            w_ifid_load   = 1'b0;
            w_idex_load   = 1'b0;
            w_exmem_load  = 1'b0;
            w_ifid_clear  = 1'b1;
            w_idex_clear  = 1'b1;
            w_exmem_clear = 1'b1;
        end else begin
            case (r_state)
                RUN: begin
                    if (hz.div_start) begin
                        // The divide itself advances normally; the stall starts next cycle.
                        w_state_nxt   = MC_BUSY;
                        w_div_cnt_nxt = DIV_RELOAD;
                    end else if (hz.branch_taken) begin
                        w_ifid_clear = 1'b1;
                        w_idex_clear = 1'b1;
                        w_flush_inc  = 1'b1;
                    end else if (w_load_use) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX.
                        w_pc_load    = 1'b0;
                        w_ifid_load  = 1'b0;
                        w_idex_clear = 1'b1;
                    end
                end
                MC_BUSY: begin
                    w_pc_load     = 1'b0;
                    w_ifid_load   = 1'b0;
                    w_idex_load   = 1'b0;
                    w_exmem_load  = 1'b0;
                    w_exmem_clear = 1'b1;
                    if (r_div_cnt == '0) begin
                        w_state_nxt = RUN;
                    end else begin
                        w_div_cnt_nxt = r_div_cnt - 8'd1;
                    end
                end
                default: begin
                    w_state_nxt = RUN;
                end
            endcase
        end
    end

    // Branch flush counter, wrapping naturally at 8 bits.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_events <= '0;
        end else if (w_flush_inc) begin
            r_flush_events <= r_flush_events + 8'd1;
        end
    end

    assign w_stall_inc = reset_n & ~w_pc_load;

    sat_counter16 u_stall_cnt (
        .clock   (clock),
        .reset_n (reset_n),
        .inc     (w_stall_inc),
        .count   (hz.stall_cycles)
    );

    assign hz.pc_load      = w_pc_load;
    assign hz.ifid_load    = w_ifid_load;
    assign hz.idex_load    = w_idex_load;
    assign hz.exmem_load   = w_exmem_load;
    assign hz.ifid_clear   = w_ifid_clear;
    assign hz.idex_clear   = w_idex_clear;
    assign hz.exmem_clear  = w_exmem_clear;
    assign hz.busy         = (r_state == MC_BUSY);
    assign hz.flush_events = r_flush_events;
    assign hz.dbg_state    = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: vector table plus hand-written multi-cycle sequences.
module tb_pipe_hazard_ctrl;

    // Control word order: {pc_load, ifid_load, idex_load, exmem_load,
    //                      ifid_clear, idex_clear, exmem_clear, busy}
    localparam logic [7:0] C_DEF  = 8'b1111_0000;
    localparam logic [7:0] C_LU   = 8'b0011_0100;
    localparam logic [7:0] C_BR   = 8'b1111_1100;
    localparam logic [7:0] C_BUSY = 8'b0000_0011;
    localparam logic [7:0] C_RST  = 8'b0000_1110;

    typedef struct {
        string      name;
        logic       mem_read;
        logic [4:0] rd;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       br;
        logic       dv;
        logic [7:0] exp_ctl;
        logic       exp_flush;
    } vec_t;

    logic clock;
    logic reset_n;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.DIV_LAT(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (bus)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];   // {ctl[7:0], stall[15:0], flush[7:0]}
    int          n_vec;
    int          n_err;
    logic [15:0] m_stall;
    logic [7:0]  m_flush;

    function automatic logic [7:0] act_ctl();
        return {bus.pc_load, bus.ifid_load, bus.idex_load, bus.exmem_load,
                bus.ifid_clear, bus.idex_clear, bus.exmem_clear, bus.busy};
    endfunction

    task automatic check_out(input string name);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: no expectation queued", name);
            return;
        end
        e = exp_q.pop_front();
        n_vec++;
        if (act_ctl() !== e[31:24]) begin
            n_err++;
            $display("FAIL %s ctl: got %b want %b", name, act_ctl(), e[31:24]);
        end
        n_vec++;
        if (bus.stall_cycles !== e[23:8]) begin
            n_err++;
            $display("FAIL %s stall_cycles: got %0d want %0d", name, bus.stall_cycles, e[23:8]);
        end
        n_vec++;
        if (bus.flush_events !== e[7:0]) begin
            n_err++;
            $display("FAIL %s flush_events: got %0d want %0d", name, bus.flush_events, e[7:0]);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic br, input logic dv);
        bus.ex_mem_read  = mr;
        bus.ex_rd        = rd;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.branch_taken = br;
        bus.div_start    = dv;
    endtask

    // One clock cycle: drive, queue the expectation, check mid-cycle, advance the model.
    task automatic step(input vec_t v);
        @(negedge clock);
        drive(v.mem_read, v.rd, v.rs, v.rt, v.br, v.dv);
        exp_q.push_back({v.exp_ctl, m_stall, m_flush});
        #2;
        check_out(v.name);
        if (!v.exp_ctl[7] && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
        if (v.exp_flush) m_flush = m_flush + 8'd1;
    endtask

    function automatic vec_t mk(input string name, input logic mr, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt, input logic br,
                                input logic dv, input logic [7:0] ctl, input logic fl);
        vec_t v;
        v.name = name; v.mem_read = mr; v.rd = rd; v.rs = rs; v.rt = rt;
        v.br = br; v.dv = dv; v.exp_ctl = ctl; v.exp_flush = fl;
        return v;
    endfunction

    vec_t vecs[10];

    // ---------------- test ----------------
    initial begin
        n_vec   = 0;
        n_err   = 0;
        m_stall = '0;
        m_flush = '0;
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        vecs[0] = mk("idle",          1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0);
        vecs[1] = mk("loaduse_rt",    1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, C_LU,  1'b0);
        vecs[2] = mk("idle_after_lu", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0);
        vecs[3] = mk("loaduse_rs",    1'b1, 5'd7, 5'd7, 5'd2, 1'b0, 1'b0, C_LU,  1'b0);
        vecs[4] = mk("r0_exempt",     1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0);
        vecs[5] = mk("no_memread",    1'b0, 5'd5, 5'd5, 5'd5, 1'b0, 1'b0, C_DEF, 1'b0);
        vecs[6] = mk("no_match",      1'b1, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0, C_DEF, 1'b0);
        vecs[7] = mk("branch",        1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR,  1'b1);
        vecs[8] = mk("branch_over_lu",1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, C_BR,  1'b1);
        vecs[9] = mk("idle_end",      1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0);

        // Reset state, checked while reset is still asserted.
        repeat (3) @(negedge clock);
        exp_q.push_back({C_RST, 16'd0, 8'd0});
        #2;
        check_out("reset_hold");
        @(negedge clock);
        reset_n = 1'b1;

        // Table vectors.
        for (int i = 0; i < 10; i++) step(vecs[i]);

        // 256 branch flushes bring flush_events back to where it started.
        for (int i = 0; i < 256; i++) step(mk("flush_loop", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BR, 1'b1));
        step(mk("flush_wrap", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0));

        // Divide stall: 7 busy cycles; branch and load-use ignored while busy,
        // and a lingering load-use is honoured on the first RUN cycle.
        step(mk("div_start", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_DEF, 1'b0));
        for (int i = 0; i < 7; i++) begin
            if (i == 2)
                step(mk("busy_branch", 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, C_BUSY, 1'b0));
            else if (i == 6)
                step(mk("busy_lu", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, C_BUSY, 1'b0));
            else
                step(mk("busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i == 4), C_BUSY, 1'b0));
        end
        step(mk("run_lu_after_div", 1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 1'b0, C_LU, 1'b0));
        step(mk("idle_after_div", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0));

        // Simultaneous div_start, branch and load-use: divide wins, no flush.
        step(mk("simul", 1'b1, 5'd4, 5'd4, 5'd4, 1'b1, 1'b1, C_DEF, 1'b0));
        for (int i = 0; i < 7; i++)
            step(mk("simul_busy", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_BUSY, 1'b0));
        step(mk("simul_done", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0));

        // Reset in the 3rd busy cycle acts without a clock edge.
        step(mk("rst_div", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, C_DEF, 1'b0));
        step(mk("rst_busy1", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_BUSY, 1'b0));
        step(mk("rst_busy2", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_BUSY, 1'b0));
        step(mk("rst_busy3", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_BUSY, 1'b0));
        #1;
        reset_n = 1'b0;
        #1;
        m_stall = '0;
        m_flush = '0;
        exp_q.push_back({C_RST, 16'd0, 8'd0});
        check_out("async_reset");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        step(mk("post_reset", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0));
        step(mk("post_reset_lu", 1'b1, 5'd8, 5'd0, 5'd8, 1'b0, 1'b0, C_LU, 1'b0));
        step(mk("post_reset_end", 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, C_DEF, 1'b0));

        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
